// File: rtl/packet_sink.sv
// packet_sink: multi-flit NoC sink with rate-limited FIFO drain, header parsing and latency statistics
module packet_sink #(
    parameter int DATA_WIDTH = 32,
    parameter int SENDER_WIDTH = 6,
    parameter int TS_WIDTH = 16,
    parameter int PKT_FLITS = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DRAIN_INTERVAL = 1,
    parameter logic [SENDER_WIDTH-1:0] MODULE_ID = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   packet_in,
    input  logic                    req_up,
    output logic                    gnt_up,
    output logic                    up_full,
    output logic                    pkt_done,
    output logic [9:0]              pkt_id,
    output logic [SENDER_WIDTH-1:0] pkt_sender,
    output logic [TS_WIDTH-1:0]     pkt_latency,
    output logic [31:0]             pkt_count,
    output logic [31:0]             latency_sum,
    output logic [TS_WIDTH-1:0]     latency_max
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = DRAIN_INTERVAL > 1 ? $clog2(DRAIN_INTERVAL) : 1;
    localparam int IW = $clog2(PKT_FLITS + 1);
    localparam logic [TW-1:0] TimerLast = TW'(DRAIN_INTERVAL - 1);
    localparam logic [IW-1:0] LastIdx = IW'(PKT_FLITS - 1);
    localparam logic [AW:0] AlmostFull = (AW + 1)'(FIFO_DEPTH - 1);

    typedef enum logic {HEAD, BODY} parseState;

    parseState state, stateNext;
    logic [DATA_WIDTH-1:0] fifoMem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] popFlit;
    logic [AW-1:0] wrPtr, rdPtr;
    logic [AW:0] count, countNext;
    logic [TW-1:0] drainTimer;
    logic [31:0] cycleCnt;
    logic [IW-1:0] flitIdx, idxNext;
    logic [9:0] idReg, curId;
    logic [SENDER_WIDTH-1:0] senderReg, curSender;
    logic [TS_WIDTH-1:0] tsReg, curTs, latency;
    logic [32:0] sumExt;
    logic push, pop, tailPop;

    assign gnt_up = req_up && !count[AW];
    assign push = gnt_up;
    assign pop = drainTimer == TimerLast && count != '0;
    assign popFlit = fifoMem[rdPtr];
    assign countNext = count + (AW + 1)'(push) - (AW + 1)'(pop);

    // A single-flit packet completes on its header pop, so fields come straight from the FIFO in HEAD
    assign curId = state == HEAD ? popFlit[DATA_WIDTH-1 -: 10] : idReg;
    assign curSender = state == HEAD ? popFlit[DATA_WIDTH-11 -: SENDER_WIDTH] : senderReg;
    assign curTs = state == HEAD ? popFlit[TS_WIDTH-1:0] : tsReg;
    assign latency = cycleCnt[TS_WIDTH-1:0] - curTs;
    assign sumExt = {1'b0, latency_sum} + 33'(latency);

    always_comb begin
        stateNext = state;
        idxNext = flitIdx;
        tailPop = 1'b0;
        if (pop) begin
            if (state == HEAD) begin
                tailPop = PKT_FLITS == 1;
                stateNext = PKT_FLITS == 1 ? HEAD : BODY;
                idxNext = IW'(1);
            end else begin
                tailPop = flitIdx == LastIdx;
                stateNext = tailPop ? HEAD : BODY;
                idxNext = flitIdx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifoMem[i] <= '0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            up_full <= 1'b0;
            drainTimer <= '0;
            cycleCnt <= '0;
            state <= HEAD;
            flitIdx <= '0;
            idReg <= '0;
            senderReg <= '0;
            tsReg <= '0;
            pkt_done <= 1'b0;
            pkt_id <= '0;
            pkt_sender <= '0;
            pkt_latency <= '0;
            pkt_count <= '0;
            latency_sum <= '0;
            latency_max <= '0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            count <= countNext;
            up_full <= countNext >= AlmostFull;
            if (push) begin
                fifoMem[wrPtr] <= packet_in;
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) rdPtr <= rdPtr + 1'b1;
            // An empty FIFO parks the timer on its last value so the next flit pops at once
            drainTimer <= drainTimer != TimerLast ? drainTimer + 1'b1 : pop ? '0 : drainTimer;
            state <= stateNext;
            flitIdx <= idxNext;
            if (pop && state == HEAD) begin
                idReg <= curId;
                senderReg <= curSender;
                tsReg <= curTs;
            end
            pkt_done <= tailPop;
            if (tailPop) begin
                pkt_id <= curId;
                pkt_sender <= curSender;
                pkt_latency <= latency;
                pkt_count <= pkt_count + 32'd1;
                latency_sum <= sumExt[32] ? '1 : sumExt[31:0];
                latency_max <= latency > latency_max ? latency : latency_max;
            end
        end
    end
endmodule

// File: tb/tb_packet_sink.sv
// tb_packet_sink: three sink configurations driven with random traffic and compared each cycle to a queue-based model
module tb_packet_sink;
    localparam int Depth = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic req [3];
    logic [63:0] din [3];
    logic gnt [3], upf [3], done [3];
    logic [9:0] pid [3];
    logic [5:0] psnd [3];
    logic [31:0] plat [3], pcnt [3], psum [3], pmax [3];
    logic [15:0] lat0, lat1, max0, max1;

    assign plat[0] = {16'h0, lat0};
    assign plat[1] = {16'h0, lat1};
    assign pmax[0] = {16'h0, max0};
    assign pmax[1] = {16'h0, max1};

    packet_sink #(.DATA_WIDTH(32), .TS_WIDTH(16), .PKT_FLITS(4), .FIFO_DEPTH(4), .DRAIN_INTERVAL(1)) u0 (
        .clk(clk), .reset(reset), .packet_in(din[0][31:0]), .req_up(req[0]), .gnt_up(gnt[0]),
        .up_full(upf[0]), .pkt_done(done[0]), .pkt_id(pid[0]), .pkt_sender(psnd[0]), .pkt_latency(lat0),
        .pkt_count(pcnt[0]), .latency_sum(psum[0]), .latency_max(max0));
    packet_sink #(.DATA_WIDTH(32), .TS_WIDTH(16), .PKT_FLITS(4), .FIFO_DEPTH(4), .DRAIN_INTERVAL(4)) u1 (
        .clk(clk), .reset(reset), .packet_in(din[1][31:0]), .req_up(req[1]), .gnt_up(gnt[1]),
        .up_full(upf[1]), .pkt_done(done[1]), .pkt_id(pid[1]), .pkt_sender(psnd[1]), .pkt_latency(lat1),
        .pkt_count(pcnt[1]), .latency_sum(psum[1]), .latency_max(max1));
    packet_sink #(.DATA_WIDTH(48), .TS_WIDTH(32), .PKT_FLITS(1), .FIFO_DEPTH(4), .DRAIN_INTERVAL(1)) u2 (
        .clk(clk), .reset(reset), .packet_in(din[2][47:0]), .req_up(req[2]), .gnt_up(gnt[2]),
        .up_full(upf[2]), .pkt_done(done[2]), .pkt_id(pid[2]), .pkt_sender(psnd[2]), .pkt_latency(plat[2]),
        .pkt_count(pcnt[2]), .latency_sum(psum[2]), .latency_max(pmax[2]));

    function automatic int dwOf(int k); return k == 2 ? 48 : 32; endfunction
    function automatic int tswOf(int k); return k == 2 ? 32 : 16; endfunction
    function automatic int pfOf(int k); return k == 2 ? 1 : 4; endfunction
    function automatic int diOf(int k); return k == 1 ? 4 : 1; endfunction

    int nChecks = 0;
    int nFails = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a plain flit queue per sink, a "next pop allowed" cycle, and a flit-of-packet counter
    logic [31:0] cyc;
    logic [63:0] mq [3][Depth];
    logic [63:0] hdr [3];
    int mh [3], ms [3], fno [3], nextPop [3];
    logic acc [3], eDone [3], eUpf [3];
    logic [9:0] eId [3];
    logic [5:0] eSnd [3];
    logic [31:0] eLat [3], eCnt [3], eSum [3], eMax [3];
    int doneSeen [3];

    task automatic modelReset();
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            mh[k] = 0; ms[k] = 0; fno[k] = 0; nextPop[k] = diOf(k) - 1;
            acc[k] = 0; eDone[k] = 0; eUpf[k] = 0; eId[k] = 0; eSnd[k] = 0;
            eLat[k] = 0; eCnt[k] = 0; eSum[k] = 0; eMax[k] = 0;
        end
    endtask

    task automatic modelStep();
        for (int k = 0; k < 3; k++) begin
            logic [63:0] f, m, lat, s;
            bit push, pop;
            m = (64'h1 << tswOf(k)) - 1;
            push = req[k] && ms[k] < Depth;
            pop = ms[k] > 0 && int'(cyc) >= nextPop[k];
            eDone[k] = 0;
            if (pop) begin
                f = mq[k][mh[k]];
                mh[k] = (mh[k] + 1) % Depth;
                ms[k]--;
                nextPop[k] = int'(cyc) + diOf(k);
                if (fno[k] == 0) hdr[k] = f;
                fno[k]++;
                if (fno[k] == pfOf(k)) begin
                    fno[k] = 0;
                    lat = (64'(cyc) - hdr[k]) & m;
                    eDone[k] = 1;
                    eId[k] = 10'(hdr[k] >> (dwOf(k) - 10));
                    eSnd[k] = 6'(hdr[k] >> (dwOf(k) - 16));
                    eLat[k] = lat[31:0];
                    eCnt[k]++;
                    s = 64'(eSum[k]) + lat;
                    eSum[k] = s > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : s[31:0];
                    if (lat[31:0] > eMax[k]) eMax[k] = lat[31:0];
                end
            end
            if (push) begin
                mq[k][(mh[k] + ms[k]) % Depth] = din[k];
                ms[k]++;
            end
            acc[k] = push;
            eUpf[k] = ms[k] >= Depth - 1;
        end
        cyc++;
    endtask

    task automatic checkAll();
        for (int k = 0; k < 3; k++) begin
            checkEq($sformatf("gnt%0d", k), gnt[k], req[k] && ms[k] < Depth);
            checkEq($sformatf("upfull%0d", k), upf[k], eUpf[k]);
            checkEq($sformatf("done%0d", k), done[k], eDone[k]);
            checkEq($sformatf("id%0d", k), pid[k], eId[k]);
            checkEq($sformatf("sender%0d", k), psnd[k], eSnd[k]);
            checkEq($sformatf("latency%0d", k), plat[k], eLat[k]);
            checkEq($sformatf("count%0d", k), pcnt[k], eCnt[k]);
            checkEq($sformatf("sum%0d", k), psum[k], eSum[k]);
            checkEq($sformatf("max%0d", k), pmax[k], eMax[k]);
            if (done[k]) doneSeen[k]++;
        end
    endtask

    // Stimulus: per-sink flit lists; headers carry either an absolute timestamp or an offset back from the write cycle
    logic [9:0] sId [3][64];
    logic [5:0] sSnd [3][64];
    logic [63:0] sTs [3][64];
    bit sHdr [3][64], sAbs [3][64];
    int sRd [3], sWr [3], gapPct [3];

    task automatic addPkt(input int k, input logic [9:0] id, input logic [5:0] snd, input logic [63:0] ts, input bit abs);
        for (int i = 0; i < pfOf(k); i++) begin
            sHdr[k][sWr[k]] = i == 0;
            sId[k][sWr[k]] = id;
            sSnd[k][sWr[k]] = snd;
            sTs[k][sWr[k]] = ts;
            sAbs[k][sWr[k]] = abs;
            sWr[k]++;
        end
    endtask

    task automatic drive();
        for (int k = 0; k < 3; k++) begin
            logic [63:0] m, dm;
            int i;
            i = sRd[k];
            m = (64'h1 << tswOf(k)) - 1;
            dm = (64'h1 << dwOf(k)) - 1;
            if (i < sWr[k] && $urandom_range(99) >= gapPct[k]) begin
                req[k] = 1'b1;
                din[k] = sHdr[k][i] ? (64'(sId[k][i]) << (dwOf(k) - 10)) | (64'(sSnd[k][i]) << (dwOf(k) - 16)) |
                         ((sAbs[k][i] ? sTs[k][i] : 64'(cyc) - sTs[k][i]) & m) : {$urandom, $urandom} & dm;
            end else req[k] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) modelStep(); else modelReset();
        @(negedge clk);
        checkAll();
        for (int k = 0; k < 3; k++) if (acc[k]) sRd[k]++;
    endtask

    function automatic bit idle();
        bit r = 1;
        for (int k = 0; k < 3; k++) if (sRd[k] != sWr[k] || ms[k] != 0 || fno[k] != 0) r = 0;
        return r;
    endfunction

    task automatic runIdle(input int budget, input string tag);
        int n = 0;
        while (!idle() && n < budget) begin
            drive();
            tick();
            n++;
        end
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        checkEq(tag, idle(), 1);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; din[k] = '0; sRd[k] = 0; sWr[k] = 0; gapPct[k] = 0; doneSeen[k] = 0;
        end
        modelReset();
        tick();
        tick();
        checkEq("reset count0", pcnt[0], 0);
        reset = 1'b1;

        // Single packet, back-to-back stream with slow drain, and random-gap single-flit packets, in parallel
        addPkt(0, 10'h155, 6'h2A, 64'd5, 0);
        for (int p = 0; p < 8; p++) addPkt(1, 10'($urandom), 6'($urandom), 64'($urandom_range(300)), 0);
        for (int p = 0; p < 20; p++) addPkt(2, 10'($urandom), 6'($urandom), 64'($urandom_range(1000)), 0);
        gapPct[2] = 40;
        runIdle(2000, "phaseA drain");
        checkEq("pkt1 count", pcnt[0], 1);
        checkEq("pkt1 id", pid[0], 10'h155);
        checkEq("pkt1 sender", psnd[0], 6'h2A);
        checkEq("pkt1 latency", plat[0], 5 + 4);
        checkEq("stream count", pcnt[1], 8);
        checkEq("single pulses", doneSeen[2], 20);
        checkEq("single max", pmax[2], eMax[2]);

        // Saturation: bring the sum to FFFF_FFF0 exactly, then add 0x100
        addPkt(2, 10'h3FF, 6'h3F, 64'(32'hFFFF_FFF0 - eSum[2] - 32'd1), 0);
        runIdle(100, "sat1 drain");
        checkEq("sum near", psum[2], 32'hFFFF_FFF0);
        addPkt(2, 10'h001, 6'h01, 64'hFF, 0);
        runIdle(100, "sat2 drain");
        checkEq("sum sat", psum[2], 32'hFFFF_FFFF);
        checkEq("sat latency", plat[2], 32'h100);

        // Reset after two flits of a packet, then a packet whose timestamp wraps
        gapPct[2] = 0;
        addPkt(0, 10'h2C3, 6'h11, 64'd3, 0);
        n = 0;
        while (sRd[0] < sWr[0] - 2 && n < 50) begin
            drive();
            tick();
            n++;
        end
        checkEq("mid flits", sWr[0] - sRd[0], 2);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) req[k] = 1'b0;
        sRd[0] = sWr[0];
        tick();
        checkEq("mid count", pcnt[0], 0);
        checkEq("mid sum", psum[2], 0);
        reset = 1'b1;
        addPkt(0, 10'h0AB, 6'h15, 64'hFFFF, 1);
        runIdle(100, "wrap drain");
        checkEq("wrap count", pcnt[0], 1);
        checkEq("wrap id", pid[0], 10'h0AB);
        checkEq("wrap latency", plat[0], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
